pattern_writer: RTL and testbench

//   Raster test-pattern generator that streams pixel writes into the LED-matrix framebuffer
//   (display write port: write_en/write_x/write_y/write_color). It replaces the fixed
//   red/blue split generator with a parametrised block that adds:
//     - selectable patterns, programmable write rate, ready backpressure,
//     - single-shot or continuous frames, and a frame-done pulse.

---
 rtl/pattern_writer.sv | 149 ++++++++++++++
 tb/tb_pattern_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_writer.sv
// Raster test-pattern generator feeding the LED-matrix framebuffer write port.
// One registered write (x, y, colour) is held until accepted; an optional divider spaces writes out.
module pattern_writer #(
    parameter int WIDTH     = 64,
    parameter int HEIGHT    = 64,
    parameter int XW        = 6,
    parameter int YW        = 6,
    parameter int CW        = 3,
    parameter int DIV_W     = 4,
    parameter int CELL_LOG2 = 3
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             start,
    input  logic             continuous,
    input  logic [2:0]       mode,
    input  logic [DIV_W-1:0] divider,
    input  logic [CW-1:0]    color_a,
    input  logic [CW-1:0]    color_b,
    input  logic             write_ready,
    output logic             write_en,
    output logic [XW-1:0]    write_x,
    output logic [YW-1:0]    write_y,
    output logic [CW-1:0]    write_color,
    output logic             busy,
    output logic             frame_done
);
    typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;

    state_t           state;
    logic [2:0]       mode_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] wait_cnt;
    logic [CW-1:0]    ca_q;
    logic [CW-1:0]    cb_q;

    logic             row_end;
    logic             last;
    logic [XW-1:0]    nx;
    logic [YW-1:0]    ny;

    function automatic logic [CW-1:0] pixel_color(
        input logic [2:0]    m,
        input logic [CW-1:0] a,
        input logic [CW-1:0] b,
        input logic [XW-1:0] x,
        input logic [YW-1:0] y
    );
        logic [31:0]   xe;
        logic [31:0]   ye;
        logic [XW-1:0] yx;
        xe = 32'(x);
        ye = 32'(y);
        yx = XW'(y);
        pixel_color = '0;
        case (m)
            3'd0: pixel_color = a;
            3'd1: pixel_color = (xe < 32'(WIDTH / 2)) ? a : b;
            3'd2: pixel_color = (ye < 32'(HEIGHT / 2)) ? a : b;
            3'd3: pixel_color = ((((xe ^ ye) >> CELL_LOG2) & 32'd1) != 32'd0) ? b : a;
            3'd4: pixel_color = x[XW-1 -: CW];
            3'd5: pixel_color = CW'(x ^ yx);
            default: pixel_color = '0;
        endcase
    endfunction

    always_comb begin
        row_end = (write_x == XW'(WIDTH - 1));
        last    = row_end && (write_y == YW'(HEIGHT - 1));
        nx      = row_end ? '0 : write_x + XW'(1);
        ny      = row_end ? write_y + YW'(1) : write_y;
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state       <= IDLE;
            mode_q      <= '0;
            div_q       <= '0;
            ca_q        <= '0;
            cb_q        <= '0;
            wait_cnt    <= '0;
            write_en    <= 1'b0;
            write_x     <= '0;
            write_y     <= '0;
            write_color <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q      <= mode;
                        div_q       <= divider;
                        ca_q        <= color_a;
                        cb_q        <= color_b;
                        write_x     <= '0;
                        write_y     <= '0;
                        write_color <= pixel_color(mode, color_a, color_b, '0, '0);
                        write_en    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    if (write_ready) begin
                        if (last) begin
                            frame_done <= 1'b1;
                            write_x    <= '0;
                            write_y    <= '0;
                            if (continuous) begin
                                mode_q      <= mode;
                                div_q       <= divider;
                                ca_q        <= color_a;
                                cb_q        <= color_b;
                                write_color <= pixel_color(mode, color_a, color_b, '0, '0);
                            end else begin
                                write_color <= '0;
                                write_en    <= 1'b0;
                                busy        <= 1'b0;
                                state       <= IDLE;
                            end
                        end else begin
                            write_x     <= nx;
                            write_y     <= ny;
                            write_color <= pixel_color(mode_q, ca_q, cb_q, nx, ny);
                        end
                        // Gap after a write uses the divider of the frame that write belonged to.
                        if ((!last || continuous) && div_q != '0) begin
                            write_en <= 1'b0;
                            wait_cnt <= div_q;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == DIV_W'(1)) begin
                        wait_cnt <= '0;
                        write_en <= 1'b1;
                        state    <= WRITE;
                    end else begin
                        wait_cnt <= wait_cnt - DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_writer.sv
// Randomized bench for pattern_writer: a cycle-level scoreboard derives every expected write
// from a pixel index and the frame's latched settings; a small 4x3 instance covers raster edges.
module tb_pattern_writer;
    localparam int W = 64, H = 64, XW = 6, YW = 6, CW = 3, DW = 4, CL = 3;
    localparam int W1 = 4, H1 = 3, XW1 = 3, YW1 = 2, CL1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, cont, rdy;
    logic [2:0]    mode;
    logic [DW-1:0] div;
    logic [CW-1:0] ca, cb;
    logic          we, busy, fd;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic [CW-1:0] wc;

    logic           s_start;
    logic [2:0]     s_mode;
    logic [CW-1:0]  s_ca, s_cb;
    logic           we1, busy1, fd1;
    logic [XW1-1:0] wx1;
    logic [YW1-1:0] wy1;
    logic [CW-1:0]  wc1;

    pattern_writer #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .CW(CW), .DIV_W(DW), .CELL_LOG2(CL)) dut (
        .clk_in(clk), .reset_n(rst_n), .start(start), .continuous(cont), .mode(mode),
        .divider(div), .color_a(ca), .color_b(cb), .write_ready(rdy), .write_en(we),
        .write_x(wx), .write_y(wy), .write_color(wc), .busy(busy), .frame_done(fd));

    pattern_writer #(.WIDTH(W1), .HEIGHT(H1), .XW(XW1), .YW(YW1), .CW(CW), .DIV_W(DW), .CELL_LOG2(CL1)) dut1 (
        .clk_in(clk), .reset_n(rst_n), .start(s_start), .continuous(1'b0), .mode(s_mode),
        .divider('0), .color_a(s_ca), .color_b(s_cb), .write_ready(1'b1), .write_en(we1),
        .write_x(wx1), .write_y(wy1), .write_color(wc1), .busy(busy1), .frame_done(fd1));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int pix_color(int m, int a, int b, int x, int y, int w, int h, int xw, int cl);
        case (m)
            0: return a;
            1: return (x < w / 2) ? a : b;
            2: return (y < h / 2) ? a : b;
            3: return (((x >> cl) ^ (y >> cl)) & 1) ? b : a;
            4: return x >> (xw - CW);
            5: return (x ^ (y % (1 << xw))) % (1 << CW);
            default: return 0;
        endcase
    endfunction

    // Scoreboard: pixel index within the frame plus remaining idle cycles before the next write.
    bit mon_en = 0, m_busy = 0, m_fd = 0, m_after_rst = 0;
    int m_gap = 0, m_pix = 0, m_mode = 0, m_a = 0, m_b = 0, m_div = 0, n_fd = 0;

    always @(negedge clk) begin
        if (fd) n_fd++;
        if (mon_en) begin
            chk("write_en", we, int'(m_busy && m_gap == 0));
            chk("busy", busy, int'(m_busy));
            chk("frame_done", fd, int'(m_fd));
            if (m_busy && m_gap == 0) begin
                chk("x", wx, m_pix % W);
                chk("y", wy, m_pix / W);
                chk("color", wc, pix_color(m_mode, m_a, m_b, m_pix % W, m_pix / W, W, H, XW, CL));
            end else if (m_after_rst) begin
                chk("rst_x", wx, 0);
                chk("rst_y", wy, 0);
                chk("rst_color", wc, 0);
            end
            m_fd = 0;
            if (!rst_n) begin
                m_busy = 0; m_gap = 0; m_pix = 0; m_after_rst = 1;
                m_mode = 0; m_a = 0; m_b = 0; m_div = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_mode = mode; m_a = ca; m_b = cb; m_div = div;
                    m_busy = 1; m_pix = 0; m_gap = 0; m_after_rst = 0;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (rdy) begin
                m_pix++;
                m_gap = m_div;
                if (m_pix == W * H) begin
                    m_pix = 0;
                    m_fd = 1;
                    if (cont) begin
                        m_mode = mode; m_a = ca; m_b = cb; m_div = div;
                    end else begin
                        m_busy = 0; m_gap = 0;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int base, input int budget);
        int i;
        for (i = 0; i < budget && n_fd <= base; i++) cyc(1);
        chk(tag, int'(n_fd > base), 1);
    endtask

    initial begin
        int i, fd0, new_a;
        rst_n = 0; start = 0; cont = 0; rdy = 1; mode = 0; div = 0; ca = 0; cb = 0;
        s_start = 0; s_mode = 0; s_ca = 0; s_cb = 0;
        cyc(1);
        mon_en = 1;
        cyc(2);
        rst_n = 1;
        cyc(3);

        // split pattern, divider 15, continuous: across the x=31/32 boundary of rows 0 and 1
        mode = 3'd1; ca = 3'b100; cb = 3'b001; div = 4'd15; cont = 1;
        pulse_start();
        cyc(16 * 140);
        rst_n = 0; cyc(2); rst_n = 1; cyc(4);

        // full frame at divider 1, then reset mid-frame at (10,5) of the next frame
        div = 4'd1;
        fd0 = n_fd;
        pulse_start();
        for (i = 0; i < 20000 && !(we && wx == 10 && wy == 5 && n_fd > fd0); i++) cyc(1);
        chk("reach_10_5", int'(we && wx == 10 && wy == 5), 1);
        chk("fd_pulses_one_frame", n_fd - fd0, 1);
        rst_n = 0; cyc(2); rst_n = 1;
        cyc(100);

        // backpressure: stall 5 cycles at (3,0), then random ready with junk inputs mid-frame
        mode = 3'($urandom_range(0, 7)); ca = 3'($urandom); cb = 3'($urandom); div = 0; cont = 0;
        fd0 = n_fd;
        pulse_start();
        for (i = 0; i < 200 && !(we && wx == 3 && wy == 0); i++) cyc(1);
        chk("reach_3_0", int'(we && wx == 3 && wy == 0), 1);
        rdy = 0;
        for (i = 0; i < 5; i++) begin
            cyc(1);
            chk("hold_x", wx, 3);
            chk("hold_en", we, 1);
        end
        rdy = 1;
        cyc(1);
        chk("after_stall_x", wx, 4);
        for (i = 0; i < 30000 && n_fd <= fd0; i++) begin
            rdy = 1'($urandom_range(0, 1));
            if (m_pix < 4000 && m_busy) begin
                start = 1'($urandom_range(0, 1));
                mode = 3'($urandom); ca = 3'($urandom); cb = 3'($urandom); div = 4'($urandom);
            end else begin
                start = 0;
                div = 0;
            end
            cyc(1);
        end
        chk("t3_frame_done", int'(n_fd > fd0), 1);
        start = 0; rdy = 1;
        cyc(5);

        // checkerboard frame
        mode = 3'd3; ca = 3'b111; cb = 3'b000; div = 0; cont = 0;
        fd0 = n_fd;
        pulse_start();
        wait_fd("t4_frame_done", fd0, 6000);
        cyc(5);

        // mid-frame mode/colour change only shows from (0,0) of the next frame
        mode = 3'd1; ca = 3'($urandom_range(0, 7)); cb = 3'($urandom); div = 4'($urandom_range(0, 2)); cont = 1;
        fd0 = n_fd;
        pulse_start();
        for (i = 0; i < 20000 && wy < 32; i++) cyc(1);
        chk("t6_reach_row32", int'(wy >= 32), 1);
        new_a = int'(ca ^ 3'b111);
        mode = 3'd0; ca = 3'(new_a);
        wait_fd("t6_frame1_done", fd0, 20000);
        for (i = 0; i < 10 && !we; i++) cyc(1);
        chk("t6_first_x", wx, 0);
        chk("t6_first_color", wc, new_a);
        cont = 0;
        wait_fd("t6_frame2_done", fd0 + 1, 20000);
        cyc(5);

        // 4x3 instance: 12 back-to-back writes, done on the 13th, start mid-frame ignored
        s_mode = 3'($urandom_range(0, 7)); s_ca = 3'($urandom); s_cb = 3'($urandom);
        s_start = 1;
        cyc(1);
        s_start = 0;
        for (i = 0; i < 12; i++) begin
            chk("t5_we", we1, 1);
            chk("t5_x", wx1, i % W1);
            chk("t5_y", wy1, i / W1);
            chk("t5_color", wc1, pix_color(s_mode, s_ca, s_cb, i % W1, i / W1, W1, H1, XW1, CL1));
            chk("t5_fd", fd1, 0);
            s_start = (i == 6);
            cyc(1);
        end
        s_start = 0;
        chk("t5_we_end", we1, 0);
        chk("t5_fd_end", fd1, 1);
        chk("t5_busy_end", busy1, 0);
        for (i = 0; i < 20; i++) begin
            cyc(1);
            chk("t5_idle_we", we1, 0);
            chk("t5_idle_fd", fd1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
